ritc_input_capture: RTL and testbench



---
 rtl/ritc_input_pkg.sv | 16 +
 rtl/ritc_lane_delay.sv | 48 ++++
 rtl/ritc_input_capture.sv | 170 +++++++++++++++++
 tb/tb_ritc_input_capture.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ritc_input_pkg.sv
// Shared definitions for the RITC input capture stage: training FSM encoding
// and the width helper used to size lane, offset and delay fields.
package ritc_input_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ARM     = 3'd1;
   localparam logic [2:0] ST_CAPTURE = 3'd2;
   localparam logic [2:0] ST_COMPUTE = 3'd3;
   localparam logic [2:0] ST_APPLY   = 3'd4;

   // Bit width needed to index n items; never less than one bit.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ritc_lane_delay.sv
// One RITC lane: differential receiver, input register, programmable delay
// line of MAX_DLY-1 stages, tap mux and registered output.
module ritc_lane_delay #(
   parameter int MAX_DLY = 8,
   parameter int DW      = 3
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          pad_p_i,
   input  logic          pad_n_i,
   input  logic [DW-1:0] dly_i,
   output logic          s_o,
   output logic          dat_o
);

   logic               pad_w;
   logic               s_q;
   logic [MAX_DLY-2:0] dl_q, dl_d;
   logic [MAX_DLY-1:0] taps_w;
   logic               dat_q, dat_d;

   // Behavioural IBUFDS: a valid differential pair resolves to the P leg.
   assign pad_w  = pad_p_i & ~pad_n_i;
   assign taps_w = {dl_q, s_q};

   always_comb begin
      dl_d  = taps_w[MAX_DLY-2:0];
      dat_d = taps_w[dly_i];
   end

   // NOTE: the delay line is reset like any other state here because dat_o
   // must read 0 out of reset regardless of the selected tap.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s_q   <= 1'b0;
         dl_q  <= '0;
         dat_q <= 1'b0;
      end else begin
         s_q   <= pad_w;
         dl_q  <= dl_d;
         dat_q <= dat_d;
      end
   end

   assign s_o   = s_q;
   assign dat_o = dat_q;

endmodule

// File: rtl/ritc_input_capture.sv
// RITC input capture: NL buffered and delayed lanes plus a training FSM that
// measures marker-edge skew per lane and programs delays to align them.
module ritc_input_capture
   import ritc_input_pkg::*;
#(
   parameter  int NCH     = 3,
   parameter  int NBITS   = 12,
   parameter  int MAX_DLY = 8,
   parameter  int WINDOW  = 64,
   localparam int NL      = NCH * NBITS,
   localparam int DW      = width_of(MAX_DLY),
   localparam int WW      = width_of(WINDOW),
   localparam int SW      = width_of(NL)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [NL-1:0] CH_P,
   input  logic [NL-1:0] CH_N,
   input  logic          train_i,
   output logic [NL-1:0] dat_o,
   output logic          busy_o,
   output logic          locked_o,
   output logic          fail_o,
   input  logic [SW-1:0] dly_sel_i,
   output logic [DW-1:0] dly_o
);

   logic [2:0]    state_q, state_d;
   logic [WW-1:0] wc_q, wc_d;
   logic [NL-1:0] found_q, found_d;
   logic [NL-1:0] prev_q, prev_d;
   logic [WW-1:0] off_q [NL];
   logic [WW-1:0] off_d [NL];
   logic [DW-1:0] nd_q  [NL];
   logic [DW-1:0] nd_d  [NL];
   logic [DW-1:0] dly_q [NL];
   logic [DW-1:0] dly_d [NL];
   logic          busy_q, busy_d, locked_q, locked_d, fail_q, fail_d;
   logic          init_q;
   logic [DW-1:0] dly_rb_q, dly_rb_d;
   logic [NL-1:0] s_w;
   logic [WW-1:0] max_off, min_off, spread;
   logic          pass;

   for (genvar l = 0; l < NL; l++) begin : g_lane
      ritc_lane_delay #(.MAX_DLY(MAX_DLY), .DW(DW)) u_lane (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .pad_p_i(CH_P[l]),
         .pad_n_i(CH_N[l]),
         .dly_i  (dly_q[l]),
         .s_o    (s_w[l]),
         .dat_o  (dat_o[l])
      );
   end

   // NOTE: every variable gets a default before the loop so no latch is
   // inferred; blocking assignments are right here because the loop chains.
   always_comb begin
      max_off = '0;
      min_off = '1;
      for (int l = 0; l < NL; l++) begin
         if (off_q[l] > max_off) max_off = off_q[l];
         if (off_q[l] < min_off) min_off = off_q[l];
      end
      spread = max_off - min_off;
      pass   = (&found_q) && (int'(spread) <= MAX_DLY - 1);
   end

   always_comb begin
      state_d  = state_q;
      wc_d     = wc_q;
      found_d  = found_q;
      prev_d   = prev_q;
      off_d    = off_q;
      nd_d     = nd_q;
      dly_d    = dly_q;
      busy_d   = busy_q;
      locked_d = locked_q;
      fail_d   = fail_q;
      case (state_q)
         ST_IDLE: begin
            // init_q masks a request arriving on the first edge after reset.
            if (train_i && !init_q) begin
               state_d  = ST_ARM;
               busy_d   = 1'b1;
               locked_d = 1'b0;
               fail_d   = 1'b0;
            end
         end
         ST_ARM: begin
            found_d = '0;
            prev_d  = s_w;
            wc_d    = '0;
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            for (int l = 0; l < NL; l++) begin
               if (!found_q[l] && s_w[l] && !prev_q[l]) begin
                  off_d[l]   = wc_q;
                  found_d[l] = 1'b1;
               end
            end
            prev_d = s_w;
            wc_d   = wc_q + 1'b1;
            if (wc_q == WW'(WINDOW - 1)) state_d = ST_COMPUTE;
         end
         ST_COMPUTE: begin
            if (pass) begin
               for (int l = 0; l < NL; l++) nd_d[l] = DW'(max_off - off_q[l]);
               state_d = ST_APPLY;
            end else begin
               fail_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         ST_APPLY: begin
            dly_d    = nd_q;
            locked_d = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      dly_rb_d = '0;
      if (int'(dly_sel_i) < NL) dly_rb_d = dly_q[dly_sel_i];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         wc_q     <= '0;
         found_q  <= '0;
         prev_q   <= '0;
         busy_q   <= 1'b0;
         locked_q <= 1'b0;
         fail_q   <= 1'b0;
         init_q   <= 1'b1;
         dly_rb_q <= '0;
         for (int l = 0; l < NL; l++) begin
            off_q[l] <= '0;
            nd_q[l]  <= '0;
            dly_q[l] <= '0;
         end
      end else begin
         state_q  <= state_d;
         wc_q     <= wc_d;
         found_q  <= found_d;
         prev_q   <= prev_d;
         busy_q   <= busy_d;
         locked_q <= locked_d;
         fail_q   <= fail_d;
         init_q   <= 1'b0;
         dly_rb_q <= dly_rb_d;
         off_q    <= off_d;
         nd_q     <= nd_d;
         dly_q    <= dly_d;
      end
   end

   assign busy_o   = busy_q;
   assign locked_o = locked_q;
   assign fail_o   = fail_q;
   assign dly_o    = dly_rb_q;

endmodule

// File: tb/tb_ritc_input_capture.sv
// Scoreboard bench for ritc_input_capture: directed training scenarios push
// expectations into queues that a negedge monitor drains and compares.
module tb_ritc_input_capture;

   localparam int NL      = 36;
   localparam int MAX_DLY = 8;
   localparam int WINDOW  = 64;
   localparam int DW      = 3;
   localparam int SW      = 6;

   localparam int K_DAT = 0, K_BUSY = 1, K_LOCKED = 2, K_FAIL = 3, K_DLY = 4;

   typedef struct {
      string       name;
      int          kind;
      logic [63:0] exp;
   } chk_t;

   typedef struct {
      string name;
      logic  locked;
      logic  fail;
      int    dur;
   } trn_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          train = 1'b0;
   logic [NL-1:0] pad = '0;
   logic [SW-1:0] sel = '0;
   logic [NL-1:0] dat_o;
   logic          busy_o, locked_o, fail_o;
   logic [DW-1:0] dly_o;

   chk_t chk_q[$];
   trn_t trn_q[$];
   int   edges[NL];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   t_start = 0;

   ritc_input_capture #(.NCH(3), .NBITS(12), .MAX_DLY(MAX_DLY), .WINDOW(WINDOW)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .CH_P     (pad),
      .CH_N     (~pad),
      .train_i  (train),
      .dat_o    (dat_o),
      .busy_o   (busy_o),
      .locked_o (locked_o),
      .fail_o   (fail_o),
      .dly_sel_i(sel),
      .dly_o    (dly_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pick(input int kind);
      case (kind)
         K_DAT:    return 64'(dat_o);
         K_BUSY:   return 64'(busy_o);
         K_LOCKED: return 64'(locked_o);
         K_FAIL:   return 64'(fail_o);
         default:  return 64'(dly_o);
      endcase
   endfunction

   task automatic expect_out(input string name, input int kind, input logic [63:0] exp);
      chk_q.push_back('{name, kind, exp});
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic readback(input int lane, input int exp, input string name);
      sel = SW'(lane);
      tick(1);
      expect_out(name, K_DLY, 64'(exp));
   endtask

   task automatic set_edges(input int e);
      for (int l = 0; l < NL; l++) edges[l] = e;
   endtask

   // Edge at c rises on the pad right after posedge c of the run, which lands
   // in window cycle c. A negative edge holds the lane low throughout.
   task automatic run_training(input string name, input logic el, input logic ef,
                               input int dur, input int pulse_at, input int rst_at);
      pad = '0;
      trn_q.push_back('{name, el, ef, dur});
      train   = 1'b1;
      t_start = cyc;
      @(negedge clk);
      train = 1'b0;
      for (int c = 0; c < WINDOW + 6; c++) begin
         for (int l = 0; l < NL; l++) pad[l] = (edges[l] >= 0) && (c >= edges[l]);
         train = (c == pulse_at);
         if (c == rst_at) rst = 1'b1;
         if (rst_at >= 0 && c == rst_at + 2) rst = 1'b0;
         @(negedge clk);
      end
      train = 1'b0;
      expect_out({name, "_idle"}, K_BUSY, 64'd0);
   endtask

   // Monitor: drains sampled expectations and scores each training run when
   // busy_o falls.
   initial begin
      logic busy_prev;
      chk_t c;
      trn_t t;
      busy_prev = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            check(c.name, pick(c.kind), c.exp);
         end
         if (busy_prev && !busy_o) begin
            if (trn_q.size() == 0) begin
               check("unexpected_busy_fall", 64'd1, 64'd0);
            end else begin
               t = trn_q.pop_front();
               check({t.name, "_locked"}, 64'(locked_o), 64'(t.locked));
               check({t.name, "_fail"}, 64'(fail_o), 64'(t.fail));
               if (t.dur >= 0) check({t.name, "_dur"}, 64'(cyc - t_start), 64'(t.dur));
            end
         end
         busy_prev = busy_o;
      end
   end

   initial begin
      // Reset with a static pattern on the pads.
      pad = 36'h5A3C96E1B;
      tick(3);
      expect_out("rst_dat", K_DAT, 64'd0);
      expect_out("rst_busy", K_BUSY, 64'd0);
      expect_out("rst_locked", K_LOCKED, 64'd0);
      expect_out("rst_fail", K_FAIL, 64'd0);
      readback(0, 0, "rst_dly0");
      readback(35, 0, "rst_dly35");

      // Release with a simultaneous train_i pulse, which must be ignored.
      rst   = 1'b0;
      train = 1'b1;
      tick(1);
      train = 1'b0;
      expect_out("rel_train_ignored", K_BUSY, 64'd0);
      expect_out("lat_dat_e1", K_DAT, 64'd0);
      tick(1);
      expect_out("lat_dat_e2", K_DAT, 64'h5A3C96E1B);
      pad = 36'hA5C3691E4;
      tick(1);
      expect_out("lat_dat_e3", K_DAT, 64'h5A3C96E1B);
      tick(1);
      expect_out("lat_dat_e4", K_DAT, 64'hA5C3691E4);
      pad = '0;
      tick(4);

      // All lanes aligned at window cycle 10.
      set_edges(10);
      run_training("t_all10", 1'b1, 1'b0, WINDOW + 4, -1, -1);
      readback(0, 0, "all10_dly0");
      readback(17, 0, "all10_dly17");
      readback(35, 0, "all10_dly35");

      // Lane 5 early by three cycles.
      set_edges(15);
      edges[5] = 12;
      run_training("t_skew5", 1'b1, 1'b0, WINDOW + 4, -1, -1);
      readback(5, 3, "skew5_dly5");
      readback(4, 0, "skew5_dly4");
      readback(40, 0, "skew5_dly_oob");

      // Skewed pad step must emerge aligned on dat_o.
      pad = '0;
      tick(MAX_DLY + 4);
      pad[5] = 1'b1;
      tick(3);
      pad = '1;
      expect_out("align_dat_a3", K_DAT, 64'd0);
      tick(1);
      expect_out("align_dat_a4", K_DAT, 64'd0);
      tick(1);
      expect_out("align_dat_a5", K_DAT, 64'hFFFFFFFFF);
      tick(2);

      // Spread of 9 exceeds the delay range.
      set_edges(5);
      edges[0]  = 2;
      edges[35] = 11;
      run_training("t_spread", 1'b0, 1'b1, WINDOW + 3, -1, -1);
      readback(5, 3, "spread_keep_dly5");
      readback(0, 0, "spread_keep_dly0");

      // Lane 17 never toggles; a second request mid-run is ignored.
      set_edges(10);
      edges[17] = -1;
      run_training("t_dead17", 1'b0, 1'b1, WINDOW + 3, 30, -1);
      readback(5, 3, "dead17_keep_dly5");

      // Reset during window cycle 20.
      set_edges(10);
      run_training("t_rst", 1'b0, 1'b0, -1, -1, 21);
      expect_out("rst_mid_busy", K_BUSY, 64'd0);
      expect_out("rst_mid_locked", K_LOCKED, 64'd0);
      expect_out("rst_mid_fail", K_FAIL, 64'd0);
      readback(5, 0, "rst_mid_dly5");
      tick(3);

      set_edges(7);
      run_training("t_after_rst", 1'b1, 1'b0, WINDOW + 4, -1, -1);
      readback(5, 0, "after_rst_dly5");
      readback(35, 0, "after_rst_dly35");

      tick(3);
      check("pending_train", 64'(trn_q.size()), 64'd0);
      check("pending_checks", 64'(chk_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
